// File: rtl/serial_compare_scheduler.sv
// ============================================================================
// Module  : serial_compare_scheduler
// Purpose : Round-robin front end that streams operand pairs MSB-first into
//           an external bit-serial comparator and returns a tagged verdict.
//           Optional macro SERIAL_CMP_EARLY_EXIT_EN ends streaming at the
//           first differing bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_compare_scheduler #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         ser_rst,
  output logic         ser_a,
  output logic         ser_b,
  input  logic         ser_less,
  input  logic         ser_eq,
  input  logic         ser_greater,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic         res_less,
  output logic         res_eq,
  output logic         res_greater
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_last_grant;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_id;
  logic [CW-1:0] r_cnt;
  logic          r_res_valid;
  logic          r_res_id;
  logic          r_res_less;
  logic          r_res_eq;
  logic          r_res_greater;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_fire;
  logic w_last_bit;

  // Requester 1 wins a tie only when requester 0 was served last.
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_grant0 = req0_valid & ~w_grant1;
  assign w_idle   = (r_state == S_IDLE) & ~rst;
  assign w_fire   = w_idle & (w_grant0 | w_grant1);

  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // An MSB-first verdict is final once the operands first differ.
  assign w_last_bit = (r_cnt == '0) | ~ser_eq;
`else
  assign w_last_bit = (r_cnt == '0);
`endif

  assign ser_rst = rst | (r_state == S_CLEAR);
  assign ser_a   = (r_state == S_SHIFT) & ~rst & r_a[r_cnt];
  assign ser_b   = (r_state == S_SHIFT) & ~rst & r_b[r_cnt];

  assign res_valid   = r_res_valid;
  assign res_id      = r_res_id;
  assign res_less    = r_res_less;
  assign res_eq      = r_res_eq;
  assign res_greater = r_res_greater;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_a           <= '0;
      r_b           <= '0;
      r_id          <= 1'b0;
      r_cnt         <= '0;
      r_res_valid   <= 1'b0;
      r_res_id      <= 1'b0;
      r_res_less    <= 1'b0;
      r_res_eq      <= 1'b0;
      r_res_greater <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_a          <= w_grant1 ? req1_a : req0_a;
            r_b          <= w_grant1 ? req1_b : req0_b;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cnt   <= CW'(W - 1);
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            r_res_valid   <= 1'b1;
            r_res_id      <= r_id;
            r_res_less    <= ser_less;
            r_res_eq      <= ser_eq;
            r_res_greater <= ser_greater;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_compare_scheduler.sv
// ============================================================================
// Module  : tb_serial_compare_scheduler
// Purpose : Self-checking bench with a behavioural serial comparator and a
//           transaction-timeline reference model of the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_compare_scheduler;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         ser_rst, ser_a, ser_b;
  logic         ser_less, ser_eq, ser_greater;
  logic         res_valid, res_ready, res_id;
  logic         res_less, res_eq, res_greater;

  int checks   = 0;
  int failures = 0;

  serial_compare_scheduler #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .ser_rst(ser_rst), .ser_a(ser_a), .ser_b(ser_b),
    .ser_less(ser_less), .ser_eq(ser_eq), .ser_greater(ser_greater),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater)
  );

  always #5 clk = ~clk;

  // Comparator: numeric comparison of all bits seen since the last clear plus the current bit.
  logic [63:0] seen_a = '0;
  logic [63:0] seen_b = '0;
  logic [64:0] cur_a, cur_b;
  always @(posedge clk) begin
    if (ser_rst) begin
      seen_a <= '0;
      seen_b <= '0;
    end else begin
      seen_a <= {seen_a[62:0], ser_a};
      seen_b <= {seen_b[62:0], ser_b};
    end
  end
  assign cur_a       = {seen_a, ser_a};
  assign cur_b       = {seen_b, ser_b};
  assign ser_less    = cur_a < cur_b;
  assign ser_eq      = cur_a == cur_b;
  assign ser_greater = cur_a > cur_b;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: transaction timeline measured in cycles since handshake.
  bit           m_busy = 1'b0;
  bit           m_last = 1'b1;
  int           m_since;
  int           m_lat;
  logic [W-1:0] m_a, m_b;
  bit           m_id;

  function automatic int latency_of(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--)
      if (a[i] != b[i]) return 2 + (W - i);
`endif
    return W + 2;
  endfunction

  task automatic step();
    bit g0, g1, exp_valid, exp_srst, exp_sa, exp_sb;
    @(negedge clk);
    if (rst) begin
      check_val("ser_rst_in_reset", ser_rst, 1);
      check_val("ser_a_in_reset", ser_a, 0);
      check_val("ser_b_in_reset", ser_b, 0);
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      g0 = 0; g1 = 0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          g0 = m_last;
          g1 = !m_last;
        end else begin
          g0 = req0_valid;
          g1 = req1_valid;
        end
      end
      check_val("req0_ready", req0_ready, g0);
      check_val("req1_ready", req1_ready, g1);
      exp_valid = m_busy && (m_since >= m_lat);
      check_val("res_valid", res_valid, exp_valid);
      if (exp_valid) begin
        check_val("res_id", res_id, m_id);
        check_val("res_less", res_less, m_a < m_b);
        check_val("res_eq", res_eq, m_a == m_b);
        check_val("res_greater", res_greater, m_a > m_b);
      end
      exp_srst = m_busy && (m_since == 1);
      exp_sa = 0; exp_sb = 0;
      if (m_busy && m_since >= 2 && m_since < m_lat) begin
        exp_sa = m_a[W - 1 - (m_since - 2)];
        exp_sb = m_b[W - 1 - (m_since - 2)];
      end
      check_val("ser_rst", ser_rst, exp_srst);
      check_val("ser_a", ser_a, exp_sa);
      check_val("ser_b", ser_b, exp_sb);
      if (g0 || g1) begin
        m_busy  = 1'b1;
        m_since = 1;
        m_id    = g1;
        m_last  = g1;
        m_a     = g1 ? req1_a : req0_a;
        m_b     = g1 ? req1_b : req0_b;
        m_lat   = latency_of(m_a, m_b);
      end else if (m_busy) begin
        if (exp_valid && res_ready) m_busy = 1'b0;
        else m_since++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req0_valid = 0;
    req1_valid = 0;
    res_ready  = 1;
    for (int n = 0; n < 60 && m_busy; n++) step();
    check_val("drain_timeout", m_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; req0_valid = 0; req1_valid = 0; res_ready = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) step();
    rst = 0;
    step();
    check_val("reset_res_id", res_id, 0);
    check_val("reset_res_less", res_less, 0);
    check_val("reset_res_eq", res_eq, 0);
    check_val("reset_res_greater", res_greater, 0);

    // Single requester, A > B.
    req0_valid = 1; req0_a = 8'h64; req0_b = 8'h62; res_ready = 1;
    step();
    drain();

    // Equal operands on requester 1.
    req1_valid = 1; req1_a = 8'hA5; req1_b = 8'hA5;
    step();
    drain();

    // Both requesters continuously valid: strict alternation.
    req0_valid = 1; req0_a = 8'd3; req0_b = 8'd5;
    req1_valid = 1; req1_a = 8'd5; req1_b = 8'd3;
    res_ready = 1;
    repeat (50) step();
    drain();

    // Backpressure in DONE while requester 1 waits.
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; res_ready = 0;
    step();
    req0_valid = 0; req1_valid = 1; req1_a = 8'h33; req1_b = 8'h11;
    for (int n = 0; n < 40 && !(m_busy && m_since >= m_lat); n++) step();
    check_val("bp_reach_done", m_busy && (m_since >= m_lat), 1);
    repeat (5) step();
    res_ready = 1;
    repeat (3) step();
    drain();

    // Decided at the MSB.
    req0_valid = 1; req0_a = 8'h80; req0_b = 8'h00;
    step();
    drain();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = W'($urandom);
      req0_b = ($urandom_range(0, 3) == 0) ? req0_a : W'($urandom);
      req1_a = W'($urandom);
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a : W'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset in the middle of streaming, then a tie goes to requester 0.
    req0_valid = 1; req0_a = 8'h5A; req0_b = 8'h5A;
    step();
    req0_valid = 0;
    for (int n = 0; n < 20 && !(m_busy && m_since == 6); n++) step();
    check_val("rst_reach_shift", m_busy && (m_since == 6), 1);
    rst = 1;
    step();
    rst = 0;
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1; req1_a = 8'h02; req1_b = 8'h01;
    step();
    check_val("rst_tie_winner", m_id, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
